// File: rtl/glb_stream_if.sv
// Stream-in / GLB-write bundle for the GLB stream loader.
// The loader consumes stream beats and drives GLB writes through the master modport.
interface glb_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 14
);
  localparam int unsigned WORD_W = 4 * DATA_W;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              glb_we;
  logic [1:0]        glb_sel;
  logic [ADDR_W-1:0] glb_addr;
  logic [WORD_W-1:0] glb_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, glb_we, glb_sel, glb_addr, glb_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, glb_we, glb_sel, glb_addr, glb_wdata
  );
endinterface

// File: rtl/glb_stream_loader.sv
// Splits one packed per-layer stream (ifmap, weight, bias) into the three GLB regions
// and generates their word addresses, including a strided weight row pitch.
module glb_stream_loader #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_IN  = 128,
  parameter int unsigned MAX_OUT = 128,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] in_dim,
  input  logic [LEN_W-1:0] out_dim,
  input  logic [LEN_W-1:0] w_row_stride,
  glb_stream_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int unsigned WORD_W = 4 * DATA_W;
  localparam int unsigned COL_W  = $clog2(MAX_IN / 4 + 1);
  localparam int unsigned ROW_W  = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_IFMAP, S_WEIGHT, S_BIAS, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  in_words_q, in_words_d;
  logic [ROW_W-1:0]  out_dim_q, out_dim_d;
  logic [ADDR_W-1:0] stride_words_q, stride_words_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              in_ready_q, in_ready_d;
  logic              glb_we_q, glb_we_d;
  logic [1:0]        glb_sel_q, glb_sel_d;
  logic [ADDR_W-1:0] glb_addr_q, glb_addr_d;
  logic [WORD_W-1:0] glb_wdata_q, glb_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic cfg_ok_c, fire_c, last_col_c, last_row_c;

  always_comb begin
    cfg_ok_c = (in_dim != '0) && (in_dim[1:0] == 2'b00) && (32'(in_dim) <= MAX_IN) &&
               (out_dim != '0) && (32'(out_dim) <= MAX_OUT) &&
               (w_row_stride[1:0] == 2'b00) && (w_row_stride >= in_dim);
    fire_c     = bus.in_valid & in_ready_q;
    last_col_c = (col_q == in_words_q - COL_W'(1));
    last_row_c = (row_q == out_dim_q - ROW_W'(1));
  end

  // Next-state, counters and registered outputs; the weight address advances by
  // adding the row pitch to a running row base instead of multiplying.
  always_comb begin
    state_d        = state_q;
    in_words_d     = in_words_q;
    out_dim_d      = out_dim_q;
    stride_words_d = stride_words_q;
    col_d          = col_q;
    row_d          = row_q;
    row_base_d     = row_base_q;
    glb_we_d       = 1'b0;
    glb_sel_d      = glb_sel_q;
    glb_addr_d     = glb_addr_q;
    glb_wdata_d    = glb_wdata_q;
    err_d          = 1'b0;
    done_d         = (state_q == S_DONE);

    if (start) begin
      if (state_q == S_IDLE && cfg_ok_c) begin
        in_words_d     = COL_W'(in_dim >> 2);
        out_dim_d      = ROW_W'(out_dim);
        stride_words_d = ADDR_W'(w_row_stride >> 2);
        col_d          = '0;
        row_d          = '0;
        row_base_d     = '0;
        state_d        = S_IFMAP;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: ;
      S_IFMAP: if (fire_c) begin
        glb_we_d    = 1'b1;
        glb_sel_d   = 2'd0;
        glb_addr_d  = ADDR_W'(col_q);
        glb_wdata_d = bus.in_data;
        if (last_col_c) begin
          col_d   = '0;
          state_d = S_WEIGHT;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_WEIGHT: if (fire_c) begin
        glb_we_d    = 1'b1;
        glb_sel_d   = 2'd1;
        glb_addr_d  = row_base_q + ADDR_W'(col_q);
        glb_wdata_d = bus.in_data;
        if (last_col_c) begin
          col_d = '0;
          if (last_row_c) begin
            row_d      = '0;
            row_base_d = '0;
            state_d    = S_BIAS;
          end else begin
            row_d      = row_q + ROW_W'(1);
            row_base_d = row_base_q + stride_words_q;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_BIAS: if (fire_c) begin
        glb_we_d    = 1'b1;
        glb_sel_d   = 2'd2;
        glb_addr_d  = ADDR_W'(row_q);
        glb_wdata_d = bus.in_data;
        if (last_row_c) begin
          row_d   = '0;
          state_d = S_DONE;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ready is a pure function of the upcoming state, so it never waits on in_valid.
    in_ready_d = (state_d == S_IFMAP) || (state_d == S_WEIGHT) || (state_d == S_BIAS);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      in_words_q     <= '0;
      out_dim_q      <= '0;
      stride_words_q <= '0;
      col_q          <= '0;
      row_q          <= '0;
      row_base_q     <= '0;
      in_ready_q     <= 1'b0;
      glb_we_q       <= 1'b0;
      glb_sel_q      <= '0;
      glb_addr_q     <= '0;
      glb_wdata_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_words_q     <= in_words_d;
      out_dim_q      <= out_dim_d;
      stride_words_q <= stride_words_d;
      col_q          <= col_d;
      row_q          <= row_d;
      row_base_q     <= row_base_d;
      in_ready_q     <= in_ready_d;
      glb_we_q       <= glb_we_d;
      glb_sel_q      <= glb_sel_d;
      glb_addr_q     <= glb_addr_d;
      glb_wdata_q    <= glb_wdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.glb_we    = glb_we_q;
  assign bus.glb_sel   = glb_sel_q;
  assign bus.glb_addr  = glb_addr_q;
  assign bus.glb_wdata = glb_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_glb_stream_loader.sv
// Directed bench for glb_stream_loader: config-check table plus full-load sequences
// compared against a GLB image built from the stream layout.
module tb_glb_stream_loader;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned LEN_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] in_dim, out_dim, w_row_stride;
  logic             busy, done, err;

  glb_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  glb_stream_loader #(
    .DATA_W(DATA_W), .MAX_IN(128), .MAX_OUT(128), .LEN_W(LEN_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_dim(in_dim), .out_dim(out_dim),
    .w_row_stride(w_row_stride), .bus(bus.master), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in_dim;
    logic [7:0] out_dim;
    logic [7:0] stride;
    logic       exp_err;
    logic       exp_busy;
  } cfg_vec_t;

  cfg_vec_t vecs [10];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] got_mem [int];
  int wr_cnt, dup_cnt, max_waddr, err_cnt, done_cnt, mon_key;
  int sel_cnt [3];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.glb_we) begin
      mon_key = int'(bus.glb_sel) * 65536 + int'(bus.glb_addr);
      if (got_mem.exists(mon_key)) dup_cnt++;
      got_mem[mon_key] = bus.glb_wdata;
      wr_cnt++;
      if (bus.glb_sel < 2'd3) sel_cnt[bus.glb_sel]++;
      if (bus.glb_sel == 2'd1 && int'(bus.glb_addr) > max_waddr) max_waddr = int'(bus.glb_addr);
    end
    if (err)  err_cnt++;
    if (done) done_cnt++;
  end

  function automatic logic [31:0] beat_data(input int j);
    return {16'hC0DE ^ 16'(j), 16'(j)};
  endfunction

  function automatic int mem_bad(input int key, input logic [31:0] exp);
    if (!got_mem.exists(key)) return 1;
    return (got_mem[key] != exp) ? 1 : 0;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_log();
    got_mem.delete();
    wr_cnt    = 0;
    dup_cnt   = 0;
    max_waddr = -1;
    sel_cnt   = '{default: 0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue_start(input int i, input int o, input int s);
    in_dim       = 8'(i);
    out_dim      = 8'(o);
    w_row_stride = 8'(s);
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_stream(input int n, input bit gaps, input int mid_at, output int first_cyc);
    int  j = 0;
    int  budget = 0;
    bit  injected = 1'b0;
    bit  acc;
    first_cyc = -1;
    while (j < n && budget < 20000) begin
      bus.in_valid = gaps ? ($urandom_range(99) < 50) : 1'b1;
      bus.in_data  = beat_data(j);
      if (j == mid_at && !injected) begin
        start    = 1'b1;
        injected = 1'b1;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc && j == 0) first_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (acc) j++;
      budget++;
    end
    bus.in_valid = 1'b0;
    check("beats_accepted", j, n);
  endtask

  task automatic wait_done(output int done_cyc);
    done_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
  endtask

  // Expected image: ifmap word k, weight (r,c) at r*pitch+c, bias word r.
  task automatic check_content(input string tag, input int i, input int o, input int s);
    int iw  = i / 4;
    int sw  = s / 4;
    int bad = 0;
    for (int k = 0; k < iw; k++) bad += mem_bad(k, beat_data(k));
    for (int r = 0; r < o; r++)
      for (int c = 0; c < iw; c++)
        bad += mem_bad(65536 + r * sw + c, beat_data(iw + r * iw + c));
    for (int r = 0; r < o; r++) bad += mem_bad(131072 + r, beat_data(iw + o * iw + r));
    check({tag, "_content"}, bad, 0);
    check({tag, "_writes"}, wr_cnt, iw + o * iw + o);
  endtask

  initial begin
    int fc, dc, e0, d0;
    vecs[0] = '{8'd6,   8'd64,  8'd64,  1'b1, 1'b0};
    vecs[1] = '{8'd64,  8'd64,  8'd32,  1'b1, 1'b0};
    vecs[2] = '{8'd0,   8'd1,   8'd4,   1'b1, 1'b0};
    vecs[3] = '{8'd132, 8'd1,   8'd132, 1'b1, 1'b0};
    vecs[4] = '{8'd4,   8'd0,   8'd4,   1'b1, 1'b0};
    vecs[5] = '{8'd4,   8'd129, 8'd4,   1'b1, 1'b0};
    vecs[6] = '{8'd64,  8'd64,  8'd66,  1'b1, 1'b0};
    vecs[7] = '{8'd8,   8'd1,   8'd4,   1'b1, 1'b0};
    vecs[8] = '{8'd4,   8'd1,   8'd4,   1'b0, 1'b1};
    vecs[9] = '{8'd128, 8'd128, 8'd128, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; in_dim = '0; out_dim = '0; w_row_stride = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    err_cnt = 0; done_cnt = 0;
    clear_log();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.in_ready, bus.glb_we, bus.glb_sel, bus.glb_addr,
                            bus.glb_wdata, busy, done, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_not_ready", bus.in_ready, 0);

    for (int v = 0; v < 10; v++) begin
      clear_log();
      issue_start(vecs[v].in_dim, vecs[v].out_dim, vecs[v].stride);
      check($sformatf("cfg%0d_err", v), err, vecs[v].exp_err);
      check($sformatf("cfg%0d_busy", v), busy, vecs[v].exp_busy);
      check($sformatf("cfg%0d_ready", v), bus.in_ready, vecs[v].exp_busy);
      @(negedge clk);
      check($sformatf("cfg%0d_err_1cyc", v), err, 0);
      check($sformatf("cfg%0d_no_write", v), wr_cnt, 0);
      do_reset();
    end

    // 64x64, stride 64, no stalls
    clear_log(); e0 = err_cnt; d0 = done_cnt;
    issue_start(64, 64, 64);
    check("full_busy", busy, 1);
    drive_stream(1104, 1'b0, -1, fc);
    wait_done(dc);
    // done lands in the 1106th cycle counting the first-beat cycle as cycle 1
    check("full_done_latency", dc - fc, 1105);
    check("full_busy_at_done", busy, 0);
    @(negedge clk);
    check("full_done_1cyc", done, 0);
    check_content("full", 64, 64, 64);
    check("full_ifmap_cnt", sel_cnt[0], 16);
    check("full_weight_cnt", sel_cnt[1], 1024);
    check("full_bias_cnt", sel_cnt[2], 64);
    check("full_last_waddr", max_waddr, 1023);
    check("full_dups", dup_cnt, 0);
    check("full_no_err", err_cnt - e0, 0);
    check("full_done_cnt", done_cnt - d0, 1);

    // stride 128
    clear_log();
    issue_start(64, 64, 128);
    drive_stream(1104, 1'b0, -1, fc);
    wait_done(dc);
    check_content("stride", 64, 64, 128);
    check("stride_r1c0", got_mem[65536 + 32], beat_data(32));
    check("stride_r63c15", got_mem[65536 + 2031], beat_data(1039));
    check("stride_last_waddr", max_waddr, 2031);

    // random stalls plus a start pulse in the middle of the weight section
    clear_log(); e0 = err_cnt;
    issue_start(64, 64, 64);
    drive_stream(1104, 1'b1, 300, fc);
    wait_done(dc);
    check_content("gaps", 64, 64, 64);
    check("gaps_dups", dup_cnt, 0);
    check("gaps_mid_start_err", err_cnt - e0, 1);

    // reset during WEIGHT, then a fresh load
    clear_log();
    issue_start(64, 64, 64);
    drive_stream(100, 1'b0, -1, fc);
    check("rst_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs", {bus.in_ready, bus.glb_we, bus.glb_sel, bus.glb_addr,
                              bus.glb_wdata, busy, done, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    issue_start(64, 64, 64);
    drive_stream(1104, 1'b0, -1, fc);
    wait_done(dc);
    check_content("after_rst", 64, 64, 64);
    check("after_rst_dups", dup_cnt, 0);

    // smallest legal layer and a start in the done cycle
    clear_log(); e0 = err_cnt;
    issue_start(4, 1, 4);
    drive_stream(3, 1'b0, -1, fc);
    wait_done(dc);
    check("tiny_done_latency", dc - fc, 4);
    check_content("tiny", 4, 1, 4);
    issue_start(4, 1, 4);
    check("b2b_busy", busy, 1);
    check("b2b_no_err", err_cnt - e0, 0);
    clear_log();
    drive_stream(3, 1'b0, -1, fc);
    wait_done(dc);
    check_content("b2b", 4, 1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/glb_stream_loader.md
Name: glb_stream_loader

Overview:
Parametrised input sequencer between the DRAM word stream and the GLB of the int8 MLP accelerator. It accepts one packed 32-bit stream per layer, made of three sections in order: ifmap, then weight, then bias. It demultiplexes the stream into the three GLB regions and generates addresses, including a configurable weight row stride. It generalises the fixed 64x64 / mode-bit load sequence to arbitrary in_dim/out_dim, adds backpressure-tolerant valid/ready input, and reports configuration errors.

Parameters:
DATA_W, 8, element width in bits; 4 elements are packed per word (WORD_W = 4*DATA_W)
MAX_IN, 128, maximum in_dim in elements
MAX_OUT, 128, maximum out_dim
LEN_W, 8, width of the dimension and stride config fields
ADDR_W, 14, GLB word address width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; latches the config while IDLE
in_dim  in  LEN_W  input features (elements), multiple of 4
out_dim  in  LEN_W  output features
w_row_stride  in  LEN_W  GLB weight row pitch in elements, multiple of 4, >= in_dim
in_valid  in  1  stream beat valid
in_ready  out  1  loader can accept a beat
in_data  in  4*DATA_W  packed beat; element 0 in the LSBs
glb_we  out  1  GLB write strobe
glb_sel  out  2  region: 0 ifmap, 1 weight, 2 bias
glb_addr  out  ADDR_W  word address within the region
glb_wdata  out  4*DATA_W  write data
busy  out  1  high from an accepted start until done
done  out  1  one-cycle pulse at the end of a load
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. Reset value 0 for in_ready, glb_we, glb_sel, glb_addr, glb_wdata, busy, done and err. State resets to IDLE.
- States: IDLE, IFMAP, WEIGHT, BIAS, DONE.
- IDLE, start=1 with a valid config: latch all three config inputs, go to IFMAP, set busy=1 on the next cycle.
- A config is valid when in_dim!=0, in_dim[1:0]==0, in_dim<=MAX_IN, 0<out_dim<=MAX_OUT, w_row_stride[1:0]==0 and w_row_stride>=in_dim.
- IDLE, start=1 with an invalid config: err=1 on the next cycle; remain in IDLE.
- start while busy: ignored, err=1 for one cycle, the current load is unaffected.
- Beat handshake: a beat is accepted on a rising edge with in_valid & in_ready. in_ready=1 only in IFMAP, WEIGHT and BIAS. It depends on state only, never on in_valid.
- IFMAP: in_dim/4 beats. Beat k is written to addr k, sel 0.
- WEIGHT: out_dim*in_dim/4 beats in row-major order (row r over 0..out_dim-1, column word c over 0..in_dim/4-1). Address = r*(w_row_stride/4) + c, sel 1. Use row and column counters; no multiplier.
- BIAS: out_dim beats. Beat r is written to addr r, sel 2. The full 32-bit word is stored unsplit.
- Write latency: a beat accepted at edge t produces glb_we=1 with addr/sel/wdata valid during the cycle after edge t. glb_we=0 in cycles with no accepted beat; stalls insert bubbles and never repeat a write.
- Section boundaries: the last beat of a section moves the state on the same edge, with no dead cycle. The next section's first beat can be accepted on the following edge.
- DONE: entered on acceptance of the last bias beat. In DONE, in_ready=0 and the last write appears. done=1 and busy=0 on the following cycle, when the state returns to IDLE.
- Back-to-back loads: a start pulse in the cycle where done=1 is accepted.
- Reset mid-operation: the state returns to IDLE and all outputs go to 0 on the next cycle. Partial GLB writes are not rolled back.
- Counter widths: sized from MAX_IN/MAX_OUT. No wrap-around within a legal config.

Test Plan:
- in_dim=64, out_dim=64, stride=64, in_valid held high -> exactly 1104 writes (16 ifmap, 1024 weight, 64 bias). Last weight addr 1023. done exactly 1106 cycles after the first accepted beat.
- in_dim=64, out_dim=64, stride=128 -> weight row 1, col 0 written to addr 32; row 63, col 15 to addr 2031. Ifmap and bias addresses are unchanged.
- Random in_valid gaps (about 50%) on the first config -> GLB contents identical to the no-stall run. Write count 1104, no duplicate addresses.
- start with in_dim=6 or w_row_stride=32<in_dim=64 -> err pulse for 1 cycle, busy stays 0, no glb_we.
- start pulsed mid-WEIGHT -> err pulse, load completes normally. rst during WEIGHT -> all outputs 0 the next cycle; a fresh start then runs a full 1104-beat load correctly.
- in_dim=4, out_dim=1 -> 3 writes (ifmap addr 0, weight addr 0, bias addr 0), then done; a start in the done cycle begins a new load.
